// File: rtl/id_exe_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_exe_stage: ID/EXE pipeline register with operand forwarding and   |
// | load-use stall detection.                        Revision: 1.0        |
// +-----------------------------------------------------------------------+
module id_exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_qa,
  input  logic [31:0] id_qb,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rn,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_aluc,
  input  logic [6:0]  id_ctl,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] exe_alu,
  input  logic [4:0]  mem_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_mo,
  output logic        stall,
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [3:0]  e_aluc,
  output logic [31:0] e_st,
  output logic [4:0]  e_rn,
  output logic [2:0]  e_ctl,
  output logic        e_valid
);

  localparam int C_USE_RT = 6;
  localparam int C_USE_RS = 5;
  localparam int C_SHIFT  = 4;
  localparam int C_ALUIMM = 3;

  logic [31:0] r_a, r_b, r_st;
  logic [3:0]  r_aluc;
  logic [4:0]  r_rn;
  logic [2:0]  r_ctl;
  logic        r_valid;

  logic        w_e_fwd_ok, w_m_fwd_ok;
  logic [31:0] w_mem_val, w_fa, w_fb, w_next_a, w_next_b;

  // EXE results from a load are not ready yet, so only non-load EXE writers forward.
  assign w_e_fwd_ok = r_ctl[0] & ~r_ctl[1] & (r_rn != 5'd0);
  assign w_m_fwd_ok = mem_wreg & (mem_rn != 5'd0);
  assign w_mem_val  = mem_m2reg ? mem_mo : mem_alu;

  always_comb begin
    w_fa = id_qa;
    if (w_e_fwd_ok && (r_rn == id_rs))
      w_fa = exe_alu;
    else if (w_m_fwd_ok && (mem_rn == id_rs))
      w_fa = w_mem_val;

    w_fb = id_qb;
    if (w_e_fwd_ok && (r_rn == id_rt))
      w_fb = exe_alu;
    else if (w_m_fwd_ok && (mem_rn == id_rt))
      w_fb = w_mem_val;
  end

  assign w_next_a = id_ctl[C_SHIFT]  ? {27'b0, id_imm[10:6]} : w_fa;
  assign w_next_b = id_ctl[C_ALUIMM] ? id_imm : w_fb;

  assign stall = r_valid & r_ctl[0] & r_ctl[1] & (r_rn != 5'd0) &
                 ((id_ctl[C_USE_RS] & (r_rn == id_rs)) |
                  (id_ctl[C_USE_RT] & (r_rn == id_rt))) &
                 id_valid & ~hold;

  always_ff @(posedge clk) begin
    if (rst || flush || (stall && !hold)) begin
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_st    <= 32'd0;
      r_aluc  <= 4'd0;
      r_rn    <= 5'd0;
      r_ctl   <= 3'd0;
      r_valid <= 1'b0;
    end else if (!hold) begin
      r_a     <= w_next_a;
      r_b     <= w_next_b;
      r_st    <= w_fb;
      r_aluc  <= id_aluc;
      r_rn    <= id_rn;
      r_ctl   <= id_valid ? id_ctl[2:0] : 3'd0;
      r_valid <= id_valid;
    end
  end

  assign e_a     = r_a;
  assign e_b     = r_b;
  assign e_st    = r_st;
  assign e_aluc  = r_aluc;
  assign e_rn    = r_rn;
  assign e_ctl   = r_ctl;
  assign e_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_id_exe_stage: vector-table bench with an expected-result queue.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_id_exe_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, flush, hold, mem_wreg, mem_m2reg;
  logic [31:0] id_qa, id_qb, id_imm, exe_alu, mem_alu, mem_mo;
  logic [4:0]  id_rs, id_rt, id_rn, mem_rn;
  logic [3:0]  id_aluc;
  logic [6:0]  id_ctl;
  logic        stall, e_valid;
  logic [31:0] e_a, e_b, e_st;
  logic [3:0]  e_aluc;
  logic [4:0]  e_rn;
  logic [2:0]  e_ctl;

  always #5 clk = ~clk;

  id_exe_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_qa(id_qa), .id_qb(id_qb),
    .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn), .id_imm(id_imm),
    .id_aluc(id_aluc), .id_ctl(id_ctl), .flush(flush), .hold(hold),
    .exe_alu(exe_alu), .mem_rn(mem_rn), .mem_wreg(mem_wreg),
    .mem_m2reg(mem_m2reg), .mem_alu(mem_alu), .mem_mo(mem_mo),
    .stall(stall), .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_st(e_st),
    .e_rn(e_rn), .e_ctl(e_ctl), .e_valid(e_valid)
  );

  typedef struct {
    logic [31:0] rst, flush, hold, valid, rs, rt, rn, qa, qb, imm, aluc, ctl;
    logic [31:0] exe_alu, mem_rn, mem_wreg, mem_m2reg, mem_alu, mem_mo;
    logic [31:0] x_stall, x_a, x_b, x_aluc, x_st, x_rn, x_ctl, x_valid;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] a, b, aluc, st, rn, ctl, valid;
  } exp_t;

  localparam int NV = 25;
  vec_t vt [NV];
  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
    end
  endtask

  // ctl encodings {use_rt,use_rs,shift,aluimm,wmem,m2reg,wreg}:
  // add/sub 0x61, lw 0x2B, sll 0x51, lui 0x09, sw 0x6C
  initial begin
    //            rst flu hld vld rs rt rn qa          qb          imm    aluc ctl   exe_alu mrn mw mm malu   mmo           | stall a       b            aluc st          rn ctl valid
    vt[0]  = '{1, 1, 1, 1, 1, 2, 3, 5,          7,          0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 0,      0,           0,  0,          0, 0,  0};
    vt[1]  = '{0, 0, 0, 1, 1, 2, 3, 5,          7,          0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 5,      7,           2,  7,          3, 1,  1};
    vt[2]  = '{0, 0, 0, 1, 6, 7, 1, 'hA,        'hB,        0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 'hA,    'hB,         2,  'hB,        1, 1,  1};
    vt[3]  = '{0, 0, 0, 1, 1, 2, 5, 1,          2,          0,     2,  'h61, 'h10, 1, 1, 0, 'h20,  0,            0, 'h10,   2,           2,  2,          5, 1,  1};
    vt[4]  = '{0, 0, 0, 1, 8, 9, 0, 3,          4,          0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 3,      4,           2,  4,          0, 1,  1};
    vt[5]  = '{0, 0, 0, 1, 1, 0, 5, 1,          'h77,       0,     2,  'h61, 'h10, 1, 1, 0, 'h20,  0,            0, 'h20,   'h77,        2,  'h77,       5, 1,  1};
    vt[6]  = '{0, 0, 0, 1, 0, 2, 7, 'h99,       2,          0,     2,  'h61, 'h10, 0, 1, 0, 'h20,  0,            0, 'h99,   2,           2,  2,          7, 1,  1};
    vt[7]  = '{0, 0, 0, 1, 9, 4, 4, 'h100,      0,          8,     2,  'h2B, 0,    0, 0, 0, 0,     0,            0, 'h100,  8,           2,  0,          4, 3,  1};
    vt[8]  = '{0, 0, 0, 1, 5, 4, 6, 'h50,       'h44,       0,     6,  'h61, 0,    0, 0, 0, 0,     0,            1, 0,      0,           0,  0,          0, 0,  0};
    vt[9]  = '{0, 0, 0, 1, 5, 4, 6, 'h50,       'h44,       0,     6,  'h61, 'h10, 4, 1, 1, 'h108, 'hDEADBEEF,   0, 'h50,   'hDEADBEEF,  6,  'hDEADBEEF, 6, 1,  1};
    vt[10] = '{0, 0, 0, 1, 0, 3, 2, 'hFFFF,     1,          'h140, 8,  'h51, 0,    0, 0, 0, 0,     0,            0, 5,      1,           8,  1,          2, 1,  1};
    vt[11] = '{0, 0, 0, 1, 0, 8, 8, 'hABC,      'h55,       'h1234,'hA,'h09, 0,    0, 0, 0, 0,     0,            0, 'hABC,  'h1234,      'hA,'h55,       8, 1,  1};
    vt[12] = '{0, 0, 1, 1, 1, 2, 9, 'h111,      'h222,      4,     2,  'h6C, 0,    0, 0, 0, 0,     0,            0, 'hABC,  'h1234,      'hA,'h55,       8, 1,  1};
    vt[13] = '{0, 0, 1, 1, 3, 4, 5, 'h333,      'h444,      0,     3,  'h61, 0,    0, 0, 0, 0,     0,            0, 'hABC,  'h1234,      'hA,'h55,       8, 1,  1};
    vt[14] = '{0, 0, 1, 0, 8, 8, 7, 'h555,      'h666,      'hF,   5,  'h2B, 'h77, 8, 1, 0, 'h88,  0,            0, 'hABC,  'h1234,      'hA,'h55,       8, 1,  1};
    vt[15] = '{0, 1, 1, 1, 1, 2, 3, 'h777,      'h888,      0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 0,      0,           0,  0,          0, 0,  0};
    vt[16] = '{0, 0, 0, 1, 1, 2, 0, 'h1000,     'hCAFE,     4,     2,  'h6C, 0,    0, 0, 0, 0,     0,            0, 'h1000, 4,           2,  'hCAFE,     0, 4,  1};
    vt[17] = '{0, 0, 0, 0, 1, 2, 3, 1,          2,          0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 1,      2,           2,  2,          3, 0,  0};
    vt[18] = '{0, 0, 0, 1, 9, 4, 4, 'h200,      0,          4,     2,  'h2B, 0,    0, 0, 0, 0,     0,            0, 'h200,  4,           2,  0,          4, 3,  1};
    vt[19] = '{0, 0, 1, 1, 5, 4, 6, 'h50,       'h44,       0,     6,  'h61, 0,    0, 0, 0, 0,     0,            0, 'h200,  4,           2,  0,          4, 3,  1};
    vt[20] = '{0, 0, 0, 0, 5, 4, 6, 'h50,       'h44,       0,     6,  'h61, 0,    0, 0, 0, 0,     0,            0, 'h50,   'h44,        6,  'h44,       6, 0,  0};
    vt[21] = '{0, 1, 0, 1, 1, 2, 3, 1,          2,          0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 0,      0,           0,  0,          0, 0,  0};
    vt[22] = '{0, 0, 0, 1, 9, 4, 4, 'h300,      0,          4,     2,  'h2B, 0,    0, 0, 0, 0,     0,            0, 'h300,  4,           2,  0,          4, 3,  1};
    vt[23] = '{0, 1, 0, 1, 4, 0, 9, 'h12,       'h34,       0,     2,  'h61, 0,    0, 0, 0, 0,     0,            1, 0,      0,           0,  0,          0, 0,  0};
    vt[24] = '{1, 0, 0, 1, 1, 2, 3, 5,          7,          0,     2,  'h61, 0,    0, 0, 0, 0,     0,            0, 0,      0,           0,  0,          0, 0,  0};

    for (int i = 0; i < NV; i++) begin
      exp_t e;
      @(negedge clk);
      rst = vt[i].rst[0];       flush = vt[i].flush[0];   hold = vt[i].hold[0];
      id_valid = vt[i].valid[0];
      id_rs = vt[i].rs[4:0];    id_rt = vt[i].rt[4:0];    id_rn = vt[i].rn[4:0];
      id_qa = vt[i].qa;         id_qb = vt[i].qb;         id_imm = vt[i].imm;
      id_aluc = vt[i].aluc[3:0]; id_ctl = vt[i].ctl[6:0];
      exe_alu = vt[i].exe_alu;  mem_rn = vt[i].mem_rn[4:0];
      mem_wreg = vt[i].mem_wreg[0]; mem_m2reg = vt[i].mem_m2reg[0];
      mem_alu = vt[i].mem_alu;  mem_mo = vt[i].mem_mo;
      e.idx = i;       e.a = vt[i].x_a;   e.b = vt[i].x_b;   e.aluc = vt[i].x_aluc;
      e.st = vt[i].x_st; e.rn = vt[i].x_rn; e.ctl = vt[i].x_ctl; e.valid = vt[i].x_valid;
      sb.push_back(e);
      #1;
      chk("stall", i, {31'b0, stall}, vt[i].x_stall);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard vec=%0d actual=empty required=entry", i);
      end else begin
        e = sb.pop_front();
        chk("e_a",     e.idx, e_a, e.a);
        chk("e_b",     e.idx, e_b, e.b);
        chk("e_aluc",  e.idx, {28'b0, e_aluc}, e.aluc);
        chk("e_st",    e.idx, e_st, e.st);
        chk("e_rn",    e.idx, {27'b0, e_rn}, e.rn);
        chk("e_ctl",   e.idx, {29'b0, e_ctl}, e.ctl);
        chk("e_valid", e.idx, {31'b0, e_valid}, e.valid);
      end
    end

    // stall must read 0 right after reset even with a would-be hazard presented
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; hold = 1'b0; id_valid = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_ctl = 7'h61;
    #1;
    chk("stall_after_rst", NV, {31'b0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
